mips_multicycle_ctrl: RTL

- Parametrised multicycle successor to the single-cycle MIPS control unit.
- Sequences each instruction through a Moore state machine: fetch, decode, execute, memory and writeback.
- Drives all datapath enables and multiplexer selects for a shared-memory multicycle datapath.
- Adds a memory ready/request handshake, a multi-cycle multiply wait, and illegal-instruction detection.

---
 rtl/mips_multicycle_ctrl.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit.
// A Moore sequencer walks each instruction through fetch, decode, execute,
// memory and writeback states and drives the enables and selects of a
// shared-memory datapath. Control outputs are registered: each clock edge
// loads the decode of the state being entered. The exceptions are ir_write
// and the fetch half of pc_write, which follow mem_ready during FETCH, and
// pc_en, which also folds in the ALU zero flag for branches.
module mips_multicycle_ctrl #(
    parameter int MUL_LATENCY   = 4,    // multiplier cycles for mul, 1..16
    parameter bit MEM_HANDSHAKE = 1'b1  // 0: mem_ready is ignored and taken as 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011100;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    // MULWAIT runs MUL_LATENCY-1 cycles: the counter starts at MUL_LATENCY-2
    // and the exit happens in the cycle it reads zero.
    localparam logic [3:0] MUL_CNT_INIT = (MUL_LATENCY > 1) ? 4'(MUL_LATENCY - 2) : 4'd0;

    // FETCH must encode as 0 so the debug state port reads 0 during reset.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_MULWAIT = 4'd7,
        S_ALUWB   = 4'd8,
        S_BEQ     = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12,
        S_ILLEGAL = 4'd13
    } state_t;

    // Registered (Moore) part of the control word. pc_write here only covers
    // JUMP; the fetch-time PC update is added combinationally.
    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal_op;
    } ctrl_t;

    state_t     state_reg;
    state_t     state_next;
    logic       run_reg;
    logic [3:0] mul_cnt_reg;
    ctrl_t      ctrl_reg;
    ctrl_t      ctrl_next;
    logic       mem_ready_eff;
    logic       funct_legal;
    logic [2:0] funct_alu;
    logic       fetch_ack;

    assign mem_ready_eff = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // Control word for a state; outputs not named here stay 0.
    function automatic ctrl_t ctrl_decode(input state_t s, input logic [2:0] exec_alu);
        ctrl_t c;
        c             = '0;
        c.alu_control = ALU_ADD;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req   = 1'b1;
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = exec_alu;
            end
            S_MULWAIT: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = ALU_MUL;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = ALU_SUB;
                c.branch      = 1'b1;
                c.pc_src      = 2'b01;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            S_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = 2'b10;
            end
            S_ILLEGAL: c.illegal_op = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    // R-type function field: legality and the ALU operation it selects.
    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = ALU_ADD;
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_SLT:  funct_alu = ALU_SLT;
            FN_MUL:  funct_alu = ALU_MUL;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            default: funct_legal = 1'b0;
        endcase
    end

    // Next-state logic. FETCH holds for one cycle after reset release so the
    // request is visible before any handshake is accepted.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:   if (run_reg && mem_ready_eff) state_next = S_DECODE;
            S_DECODE: begin
                case (op_code)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = funct_legal ? S_EXECUTE : S_ILLEGAL;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  state_next = (op_code == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready_eff) state_next = S_MEMWB;
            S_MEMWB:   state_next = S_FETCH;
            S_MEMWR:   if (mem_ready_eff) state_next = S_FETCH;
            S_EXECUTE: state_next = (funct == FN_MUL && MUL_LATENCY > 1) ? S_MULWAIT : S_ALUWB;
            S_MULWAIT: if (mul_cnt_reg == 4'd0) state_next = S_ALUWB;
            S_ALUWB:   state_next = S_FETCH;
            S_BEQ:     state_next = S_FETCH;
            S_ADDIEX:  state_next = S_ADDIWB;
            S_ADDIWB:  state_next = S_FETCH;
            S_JUMP:    state_next = S_FETCH;
            S_ILLEGAL: state_next = S_FETCH;
            default:   state_next = S_FETCH;
        endcase
    end

    // Control word of the state about to be entered, so outputs are registered.
    always_comb begin
        ctrl_next = ctrl_decode(state_next, funct_alu);
    end

    // State, multiply wait counter and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_FETCH;
            run_reg     <= 1'b0;
            mul_cnt_reg <= 4'd0;
            ctrl_reg    <= '0;
        end else begin
            state_reg <= state_next;
            run_reg   <= 1'b1;
            ctrl_reg  <= ctrl_next;
            if (state_reg == S_EXECUTE && state_next == S_MULWAIT) begin
                mul_cnt_reg <= MUL_CNT_INIT;
            end else if (state_reg == S_MULWAIT && mul_cnt_reg != 4'd0) begin
                mul_cnt_reg <= mul_cnt_reg - 4'd1;
            end
        end
    end

    // Instruction accepted from memory: load IR and advance PC by 4.
    assign fetch_ack = (state_reg == S_FETCH) && run_reg && mem_ready_eff;

    assign mem_req     = ctrl_reg.mem_req;
    assign iord        = ctrl_reg.iord;
    assign mem_write   = ctrl_reg.mem_write;
    assign ir_write    = fetch_ack;
    assign pc_en       = fetch_ack | ctrl_reg.pc_write | (ctrl_reg.branch & zero);
    assign pc_src      = ctrl_reg.pc_src;
    assign alu_src_a   = ctrl_reg.alu_src_a;
    assign alu_src_b   = ctrl_reg.alu_src_b;
    assign alu_control = ctrl_reg.alu_control;
    assign reg_dst     = ctrl_reg.reg_dst;
    assign mem_to_reg  = ctrl_reg.mem_to_reg;
    assign reg_write   = ctrl_reg.reg_write;
    assign illegal_op  = ctrl_reg.illegal_op;
    assign state       = state_reg;

endmodule
